// File: rtl/hist_peak_finder_pkg.sv
// hist_peak_finder_pkg: default sizing, derived index widths and FSM state
// encoding shared by the histogram peak finder and its comparator.
package hist_peak_finder_pkg;

    localparam int BIN_NUM_DEF   = 16;
    localparam int PIXEL_NUM_DEF = 4;
    localparam int CNT_W_DEF     = 8;

    // Index width for n entries; never below one bit so a single-entry
    // dimension still has a legal (constant zero) index field.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int BIN_W_DEF = idx_width(BIN_NUM_DEF);
    localparam int PIX_W_DEF = idx_width(PIXEL_NUM_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/hist_peak_finder_peak_cmp.sv
// hist_peak_finder_peak_cmp: running maximum of a stream of bin counts.
// A new sample replaces the stored maximum only when strictly greater, so the
// earliest (lowest-index) bin wins ties. clr restarts at count 0, index 0.
module hist_peak_finder_peak_cmp #(
    parameter int CNT_W = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clr,
    input  logic             vld,
    input  logic [CNT_W-1:0] data,
    input  logic [IDX_W-1:0] idx,
    output logic [CNT_W-1:0] max_cnt,
    output logic [IDX_W-1:0] max_idx
);

    logic [CNT_W-1:0] max_cnt_r;
    logic [IDX_W-1:0] max_idx_r;
    logic             take_s;

    // Strict unsigned full-width comparison of the incoming sample
    always_comb begin
        take_s = 1'b0;
        if (vld && (data > max_cnt_r)) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
    end

    // Running maximum and its bin index; clear has priority over update
    always_ff @(posedge clk) begin
        if (res || clr) begin
            max_cnt_r <= {CNT_W{1'b0}};
            max_idx_r <= {IDX_W{1'b0}};
        end else if (take_s) begin
            max_cnt_r <= data;
            max_idx_r <= idx;
        end else begin
            max_cnt_r <= max_cnt_r;
            max_idx_r <= max_idx_r;
        end
    end

    assign max_cnt = max_cnt_r;
    assign max_idx = max_idx_r;

endmodule

// File: rtl/hist_peak_finder.sv
// hist_peak_finder: scans a completed histogram bank pixel by pixel, finds the
// bin with the highest count for each pixel and hands {pixel, bin, count} to a
// ready/valid consumer. A toggle on hisNum marks a finished bank; one extra
// bank can be queued while busy, further ones raise the sticky overrun flag.
// Optional build macro PEAK_THRESH_EN adds input peakThresh: peaks at or
// below the threshold are reported as bin 0, count 0.
module hist_peak_finder
    import hist_peak_finder_pkg::*;
#(
    parameter  int BIN_NUM   = BIN_NUM_DEF,
    parameter  int PIXEL_NUM = PIXEL_NUM_DEF,
    parameter  int CNT_W     = CNT_W_DEF,
    localparam int PIX_W     = idx_width(PIXEL_NUM),
    localparam int BIN_W     = idx_width(BIN_NUM)
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   hisNum,
    output logic                   rdEn,
    output logic                   rdBank,
    output logic [PIX_W+BIN_W-1:0] rdAddr,
    input  logic [CNT_W-1:0]       rdData,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [PIX_W-1:0]       outPixel,
    output logic [BIN_W-1:0]       outBin,
    output logic [CNT_W-1:0]       outCount,
    output logic                   busy,
    output logic                   overrun
`ifdef PEAK_THRESH_EN
    ,
    input  logic [CNT_W-1:0]       peakThresh
`endif
);

    state_e           state_r;
    state_e           state_s;

    logic             hisnum_r;
    logic [PIX_W-1:0] pix_r;
    logic [BIN_W-1:0] bin_r;
    logic             rd_en_r;
    logic             rd_bank_r;
    logic             cmp_vld_r;
    logic [BIN_W-1:0] cmp_idx_r;
    logic             pending_r;
    logic             overrun_r;
    logic             busy_r;
    logic             out_valid_r;
    logic [PIX_W-1:0] out_pixel_r;
    logic [BIN_W-1:0] out_bin_r;
    logic [CNT_W-1:0] out_count_r;

    logic             event_s;
    logic             last_bin_s;
    logic             last_pix_s;
    logic             handshake_s;
    logic             rd_en_s;
    logic             busy_s;
    logic             out_valid_s;
    logic             start_s;
    logic             clr_s;
    logic             load_s;
    logic             keep_s;
    logic             pending_s;
    logic             overrun_s;
    logic [BIN_W-1:0] out_bin_s;
    logic [CNT_W-1:0] out_count_s;
    logic [CNT_W-1:0] max_cnt_s;
    logic [BIN_W-1:0] max_idx_s;

    assign event_s     = hisNum ^ hisnum_r;
    assign last_bin_s  = (bin_r == BIN_W'(BIN_NUM - 1));
    assign last_pix_s  = (pix_r == PIX_W'(PIXEL_NUM - 1));
    assign handshake_s = (state_r == ST_OUT) && out_valid_r && outReady;

    // FSM state register
    always_ff @(posedge clk) begin
        if (res) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; DRAIN waits until the last read's data has been compared
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (event_s || pending_r) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (last_bin_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (!cmp_vld_r) begin
                    state_s = ST_OUT;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_OUT: begin
                if (handshake_s) begin
                    if (last_pix_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_READ;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: next-cycle values for registered outputs and queue flags
    always_comb begin
        rd_en_s     = (state_s == ST_READ);
        busy_s      = (state_s != ST_IDLE);
        out_valid_s = (state_s == ST_OUT);
        start_s     = (state_r == ST_IDLE) && (state_s == ST_READ);
        clr_s       = (state_r != ST_READ) && (state_s == ST_READ);
        load_s      = (state_r == ST_DRAIN) && (state_s == ST_OUT);

`ifdef PEAK_THRESH_EN
        if (max_cnt_s > peakThresh) begin
            keep_s = 1'b1;
        end else begin
            keep_s = 1'b0;
        end
`else
        keep_s = 1'b1;
`endif

        if (keep_s) begin
            out_bin_s   = max_idx_s;
            out_count_s = max_cnt_s;
        end else begin
            out_bin_s   = {BIN_W{1'b0}};
            out_count_s = {CNT_W{1'b0}};
        end

        // A start consumes one of (pending, event); the other stays queued.
        pending_s = pending_r;
        overrun_s = overrun_r;
        if (start_s) begin
            pending_s = pending_r & event_s;
        end else if (event_s) begin
            if (pending_r) begin
                overrun_s = 1'b1;
            end else begin
                pending_s = 1'b1;
            end
        end else begin
            pending_s = pending_r;
        end
    end

    // Read-side registers: address counters, strobe, bank select, compare pipe
    always_ff @(posedge clk) begin
        if (res) begin
            hisnum_r  <= hisNum;
            pix_r     <= {PIX_W{1'b0}};
            bin_r     <= {BIN_W{1'b0}};
            rd_en_r   <= 1'b0;
            rd_bank_r <= 1'b0;
            cmp_vld_r <= 1'b0;
            cmp_idx_r <= {BIN_W{1'b0}};
            pending_r <= 1'b0;
            overrun_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            hisnum_r  <= hisNum;
            rd_en_r   <= rd_en_s;
            busy_r    <= busy_s;
            cmp_vld_r <= rd_en_r;
            cmp_idx_r <= bin_r;
            pending_r <= pending_s;
            overrun_r <= overrun_s;
            if (start_s) begin
                rd_bank_r <= ~hisnum_r;
            end else begin
                rd_bank_r <= rd_bank_r;
            end
            if (clr_s) begin
                bin_r <= {BIN_W{1'b0}};
            end else if (state_r == ST_READ) begin
                bin_r <= bin_r + BIN_W'(1);
            end else begin
                bin_r <= bin_r;
            end
            if (start_s) begin
                pix_r <= {PIX_W{1'b0}};
            end else if (handshake_s) begin
                pix_r <= last_pix_s ? {PIX_W{1'b0}} : (pix_r + PIX_W'(1));
            end else begin
                pix_r <= pix_r;
            end
        end
    end

    // Result registers: captured once per pixel, held until accepted
    always_ff @(posedge clk) begin
        if (res) begin
            out_valid_r <= 1'b0;
            out_pixel_r <= {PIX_W{1'b0}};
            out_bin_r   <= {BIN_W{1'b0}};
            out_count_r <= {CNT_W{1'b0}};
        end else begin
            out_valid_r <= out_valid_s;
            if (load_s) begin
                out_pixel_r <= pix_r;
                out_bin_r   <= out_bin_s;
                out_count_r <= out_count_s;
            end else begin
                out_pixel_r <= out_pixel_r;
                out_bin_r   <= out_bin_r;
                out_count_r <= out_count_r;
            end
        end
    end

    hist_peak_finder_peak_cmp #(
        .CNT_W (CNT_W),
        .IDX_W (BIN_W)
    ) u_peak_cmp (
        .clk     (clk),
        .res     (res),
        .clr     (clr_s),
        .vld     (cmp_vld_r),
        .data    (rdData),
        .idx     (cmp_idx_r),
        .max_cnt (max_cnt_s),
        .max_idx (max_idx_s)
    );

    assign rdEn     = rd_en_r;
    assign rdBank   = rd_bank_r;
    assign rdAddr   = {pix_r, bin_r};
    assign outValid = out_valid_r;
    assign outPixel = out_pixel_r;
    assign outBin   = out_bin_r;
    assign outCount = out_count_r;
    assign busy     = busy_r;
    assign overrun  = overrun_r;

endmodule

// File: tb/tb_hist_peak_finder.sv
// tb_hist_peak_finder: directed scenarios for hist_peak_finder with a
// registered-read histogram RAM model (two banks of 4 pixels x 16 bins).
module tb_hist_peak_finder;

    logic       clk;
    logic       res;
    logic       hisNum;
    logic       rdEn;
    logic       rdBank;
    logic [5:0] rdAddr;
    logic [7:0] rdData;
    logic       outValid;
    logic       outReady;
    logic [1:0] outPixel;
    logic [3:0] outBin;
    logic [7:0] outCount;
    logic       busy;
    logic       overrun;
`ifdef PEAK_THRESH_EN
    logic [7:0] peakThresh;
`endif

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [7:0] mem [0:1][0:63];

    hist_peak_finder dut (
        .clk        (clk),
        .res        (res),
        .hisNum     (hisNum),
        .rdEn       (rdEn),
        .rdBank     (rdBank),
        .rdAddr     (rdAddr),
        .rdData     (rdData),
        .outValid   (outValid),
        .outReady   (outReady),
        .outPixel   (outPixel),
        .outBin     (outBin),
        .outCount   (outCount),
        .busy       (busy),
        .overrun    (overrun)
`ifdef PEAK_THRESH_EN
        ,
        .peakThresh (peakThresh)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Histogram RAM: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (rdEn) rdData <= mem[rdBank][rdAddr];
    end

    task automatic fill_bank(input logic b, input logic [7:0] v);
        for (int i = 0; i < 64; i++) mem[b][i] = v;
    endtask

    task automatic test_reset();
        res = 1'b1; hisNum = 1'b0; outReady = 1'b1;
        repeat (2) @(negedge clk);
        hisNum = 1'b1;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if ({rdEn, outValid, busy, overrun} !== 4'b0000) begin
            miss_cnt++;
            $display("FAIL reset_ctrl: got %b expected 0000", {rdEn, outValid, busy, overrun});
        end
        vec_cnt++;
        if ({rdAddr, rdBank} !== 7'd0) begin
            miss_cnt++;
            $display("FAIL reset_rd: got addr %0d bank %0d expected 0 0", rdAddr, rdBank);
        end
        vec_cnt++;
        if ({outPixel, outBin, outCount} !== 14'd0) begin
            miss_cnt++;
            $display("FAIL reset_out: got %0d/%0d/%0d expected 0/0/0", outPixel, outBin, outCount);
        end
        res = 1'b0;
        repeat (4) @(negedge clk);
        vec_cnt++;
        if ({busy, rdEn} !== 2'b00) begin
            miss_cnt++;
            $display("FAIL no_spurious_event: got busy %b rdEn %b expected 0 0", busy, rdEn);
        end
    endtask

    task automatic test_single_peak();
        logic [7:0] exp_cnt [4];
        logic [3:0] exp_bin [4];
        logic bnk;
        bit ok;
        int lat;
        exp_cnt = '{8'd50, 8'd200, 8'd7, 8'd255};
        exp_bin = '{4'd3, 4'd15, 4'd0, 4'd8};
        bnk = ~hisNum;
        fill_bank(bnk, 8'd0);
        fill_bank(~bnk, 8'hFF);
        mem[bnk][3]  = 8'd50;  mem[bnk][9]  = 8'd50;
        mem[bnk][31] = 8'd200;
        mem[bnk][32] = 8'd7;   mem[bnk][37] = 8'd7;
        mem[bnk][50] = 8'd254; mem[bnk][56] = 8'd255;
        outReady = 1'b1;
        @(negedge clk);
        hisNum = ~hisNum;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdEn === 1'b1) begin ok = 1'b1; break; end
        end
        vec_cnt++;
        if (!ok || rdBank !== bnk || rdAddr !== 6'd0) begin
            miss_cnt++;
            $display("FAIL first_read: got rdEn %b bank %b addr %0d expected 1 %b 0", rdEn, rdBank, rdAddr, bnk);
        end
        lat = 0;
        while (outValid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        vec_cnt++;
        if (lat != 18) begin
            miss_cnt++;
            $display("FAIL latency: got %0d cycles expected 18", lat);
        end
        for (int p = 0; p < 4; p++) begin
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (outValid === 1'b1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            vec_cnt++;
            if (!ok) begin
                miss_cnt++;
                $display("FAIL peak_timeout: pixel %0d got no outValid expected outValid", p);
            end else if ({outPixel, outBin, outCount} !== {p[1:0], exp_bin[p], exp_cnt[p]}) begin
                miss_cnt++;
                $display("FAIL peak_pix%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         p, outPixel, outBin, outCount, p, exp_bin[p], exp_cnt[p]);
            end
            @(negedge clk);
        end
        vec_cnt++;
        if (busy !== 1'b0) begin
            miss_cnt++;
            $display("FAIL peak_busy_end: got %b expected 0", busy);
        end
    endtask

    task automatic test_all_zero();
        logic bnk;
        bit ok;
        bnk = ~hisNum;
        fill_bank(bnk, 8'd0);
        fill_bank(~bnk, 8'hFF);
        @(negedge clk);
        hisNum = ~hisNum;
        for (int p = 0; p < 4; p++) begin
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (outValid === 1'b1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            vec_cnt++;
            if (!ok || {outPixel, outBin, outCount} !== {p[1:0], 4'd0, 8'd0}) begin
                miss_cnt++;
                $display("FAIL zero_pix%0d: got v%b %0d/%0d/%0d expected v1 %0d/0/0",
                         p, outValid, outPixel, outBin, outCount, p);
            end
            @(negedge clk);
        end
        vec_cnt++;
        if (busy !== 1'b0) begin
            miss_cnt++;
            $display("FAIL zero_busy_end: got %b expected 0", busy);
        end
    endtask

    task automatic test_backpressure();
        logic bnk;
        bit ok;
        bnk = ~hisNum;
        fill_bank(bnk, 8'd1);
        fill_bank(~bnk, 8'hFF);
        for (int p = 0; p < 4; p++) mem[bnk][p*16 + p + 4] = 8'(10 * (p + 1));
        outReady = 1'b0;
        @(negedge clk);
        hisNum = ~hisNum;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (outValid === 1'b1) begin ok = 1'b1; break; end
        end
        for (int k = 0; k < 5; k++) begin
            vec_cnt++;
            if (!ok || {outValid, rdEn, outPixel, outBin, outCount} !== {1'b1, 1'b0, 2'd0, 4'd4, 8'd10}) begin
                miss_cnt++;
                $display("FAIL hold_cyc%0d: got v%b rd%b %0d/%0d/%0d expected v1 rd0 0/4/10",
                         k, outValid, rdEn, outPixel, outBin, outCount);
            end
            @(negedge clk);
        end
        outReady = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if ({rdEn, outValid, rdAddr} !== {1'b1, 1'b0, 6'd16}) begin
            miss_cnt++;
            $display("FAIL resume_scan: got rdEn %b outValid %b addr %0d expected 1 0 16", rdEn, outValid, rdAddr);
        end
        for (int p = 1; p < 4; p++) begin
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (outValid === 1'b1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            vec_cnt++;
            if (!ok || {outPixel, outBin, outCount} !== {p[1:0], 4'(p + 4), 8'(10 * (p + 1))}) begin
                miss_cnt++;
                $display("FAIL bp_pix%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         p, outPixel, outBin, outCount, p, p + 4, 10 * (p + 1));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_pending_overrun();
        logic bank_a;
        logic bank_b;
        bit ok;
        bank_a = ~hisNum;
        bank_b = hisNum;
        fill_bank(bank_a, 8'd0);
        fill_bank(bank_b, 8'd3);
        for (int p = 0; p < 4; p++) begin
            mem[bank_a][p*16 + 1]  = 8'(100 + p);
            mem[bank_b][p*16 + 14] = 8'(60 + p);
        end
        outReady = 1'b1;
        @(negedge clk);
        hisNum = ~hisNum;
        repeat (3) @(negedge clk);
        hisNum = ~hisNum;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if ({busy, overrun} !== 2'b10) begin
            miss_cnt++;
            $display("FAIL pend_first: got busy %b overrun %b expected 1 0", busy, overrun);
        end
        hisNum = ~hisNum;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if (overrun !== 1'b1) begin
            miss_cnt++;
            $display("FAIL overrun_set: got %b expected 1", overrun);
        end
        for (int p = 0; p < 4; p++) begin
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (outValid === 1'b1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            vec_cnt++;
            if (!ok || {outPixel, outBin, outCount} !== {p[1:0], 4'd1, 8'(100 + p)}) begin
                miss_cnt++;
                $display("FAIL bankA_pix%0d: got %0d/%0d/%0d expected %0d/1/%0d",
                         p, outPixel, outBin, outCount, p, 100 + p);
            end
            @(negedge clk);
        end
        vec_cnt++;
        if ({busy, rdEn} !== 2'b00) begin
            miss_cnt++;
            $display("FAIL idle_gap: got busy %b rdEn %b expected 0 0", busy, rdEn);
        end
        @(negedge clk);
        vec_cnt++;
        if ({rdEn, rdBank} !== {1'b1, bank_b}) begin
            miss_cnt++;
            $display("FAIL pend_start: got rdEn %b bank %b expected 1 %b", rdEn, rdBank, bank_b);
        end
        for (int p = 0; p < 4; p++) begin
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (outValid === 1'b1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            vec_cnt++;
            if (!ok || {outPixel, outBin, outCount} !== {p[1:0], 4'd14, 8'(60 + p)}) begin
                miss_cnt++;
                $display("FAIL bankB_pix%0d: got %0d/%0d/%0d expected %0d/14/%0d",
                         p, outPixel, outBin, outCount, p, 60 + p);
            end
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        vec_cnt++;
        if ({busy, overrun} !== 2'b01) begin
            miss_cnt++;
            $display("FAIL single_depth: got busy %b overrun %b expected 0 1", busy, overrun);
        end
    endtask

    task automatic test_reset_midscan();
        bit ok;
        bit seen;
        fill_bank(1'b0, 8'd9);
        fill_bank(1'b1, 8'd9);
        outReady = 1'b1;
        @(negedge clk);
        hisNum = ~hisNum;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdEn === 1'b1 && rdAddr === 6'd23) begin ok = 1'b1; break; end
        end
        vec_cnt++;
        if (!ok) begin
            miss_cnt++;
            $display("FAIL reach_bin7: got no read of addr 23 expected one");
        end
        res = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if ({busy, rdEn, rdBank, outValid, overrun} !== 5'b00000) begin
            miss_cnt++;
            $display("FAIL midscan_reset: got %b expected 00000", {busy, rdEn, rdBank, outValid, overrun});
        end
        res = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (outValid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        vec_cnt++;
        if (seen) begin
            miss_cnt++;
            $display("FAIL abandon_bank: got activity after reset expected none");
        end
    endtask

`ifdef PEAK_THRESH_EN
    task automatic test_thresh();
        logic [3:0] exp_bin [4];
        logic [7:0] exp_cnt [4];
        logic bnk;
        bit ok;
        exp_bin = '{4'd0, 4'd5, 4'd0, 4'd5};
        exp_cnt = '{8'd0, 8'd21, 8'd0, 8'd255};
        bnk = ~hisNum;
        fill_bank(bnk, 8'd0);
        fill_bank(~bnk, 8'hFF);
        mem[bnk][5]  = 8'd20;
        mem[bnk][21] = 8'd21;
        mem[bnk][53] = 8'd255;
        peakThresh = 8'd20;
        outReady = 1'b1;
        @(negedge clk);
        hisNum = ~hisNum;
        for (int p = 0; p < 4; p++) begin
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (outValid === 1'b1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            vec_cnt++;
            if (!ok || {outPixel, outBin, outCount} !== {p[1:0], exp_bin[p], exp_cnt[p]}) begin
                miss_cnt++;
                $display("FAIL thresh_pix%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         p, outPixel, outBin, outCount, p, exp_bin[p], exp_cnt[p]);
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res = 1'b1;
        hisNum = 1'b0;
        outReady = 1'b1;
`ifdef PEAK_THRESH_EN
        peakThresh = 8'd0;
`endif
        test_reset();
        test_single_peak();
        test_all_zero();
        test_backpressure();
        test_pending_overrun();
        test_reset_midscan();
`ifdef PEAK_THRESH_EN
        test_thresh();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/hist_peak_finder.md
HIST_PEAK_FINDER -- requirements
Module: hist_peak_finder

Interface
REQ-001 Parameter BIN_NUM, 16: histogram bins per pixel, power of two, at least 4.
REQ-002 Parameter PIXEL_NUM, 4: pixels per histogram bank, power of two.
REQ-003 Parameter CNT_W, 8: bin-count width.
REQ-004 clk  in  1: single clock; all logic on its rising edge.
REQ-005 res  in  1: reset, synchronous, active-high.
REQ-006 hisNum  in  1: bank-complete toggle from the histogram builder.
REQ-007 rdEn  out  1: histogram RAM read strobe.
REQ-008 rdBank  out  1: RAM bank being read.
REQ-009 rdAddr  out  PIX_W+BIN_W: {pixel, bin}, where PIX_W = clog2(PIXEL_NUM) and BIN_W = clog2(BIN_NUM).
REQ-010 rdData  in  CNT_W: RAM data, valid exactly one cycle after rdEn.
REQ-011 outValid  out  1: peak result valid.
REQ-012 outReady  in  1: consumer accepts the result.
REQ-013 outPixel  out  PIX_W: pixel index of the result.
REQ-014 outBin  out  BIN_W: bin index of the peak.
REQ-015 outCount  out  CNT_W: count at the peak bin.
REQ-016 busy  out  1: high in any state other than IDLE.
REQ-017 overrun  out  1: sticky flag, set when a bank-complete event is lost.

Function
REQ-018 A bank-complete event is any change of hisNum relative to its value registered on the previous cycle.
REQ-019 FSM states and transitions:
- IDLE -> READ on an event or a pending flag.
- READ -> DRAIN after bin BIN_NUM-1 is issued.
- DRAIN -> OUT.
- OUT -> READ (next pixel) on handshake when the pixel is not last.
- OUT -> IDLE on handshake when the pixel is last.
REQ-020 On entry to READ from IDLE, rdBank is set to the inverse of the current registered hisNum and held for all pixels of the bank.
REQ-021 In READ, rdEn is high every cycle and the bin index increments 0..BIN_NUM-1, giving BIN_NUM consecutive reads per pixel.
REQ-022 Each rdData is compared one cycle after its read; a bin replaces the running max only if its count is strictly greater, so the lowest index wins ties.
REQ-023 The running max is cleared to count 0, bin 0 at the start of each pixel; an all-zero pixel therefore reports bin 0, count 0.
REQ-024 In OUT, outValid is high and outPixel/outBin/outCount are stable until the cycle where outValid and outReady are both high.
REQ-025 Minimum per-pixel latency is BIN_NUM+2 cycles from the first rdEn to outValid being high with outReady high.
REQ-026 An event arriving while busy sets the pending flag; the bank is processed immediately after the return to IDLE, with one IDLE cycle.
REQ-027 An event arriving while the pending flag is already set sets overrun; the flag remains single-depth.
REQ-028 Counts are unsigned and the comparison is full-width; there is no saturation or wrap.

Reset
REQ-029 While res is high:
- FSM returns to IDLE.
- rdEn, outValid, busy and overrun are 0.
- outPixel, outBin, outCount, rdAddr and rdBank are 0.
- The pending flag is cleared.
- The registered hisNum copies the current hisNum, so no spurious event follows reset.
REQ-030 A reset in mid-scan or in OUT abandons the current bank with no result emitted.

Configuration
REQ-031 Macro PEAK_THRESH_EN adds an input port peakThresh, width CNT_W.
REQ-032 With PEAK_THRESH_EN, a pixel whose max count is at or below peakThresh reports outBin 0 and outCount 0, and is still emitted.
REQ-033 Without PEAK_THRESH_EN, the peakThresh port does not exist and every pixel reports its raw max.

Structure
REQ-034 Shared include: BIN_NUM, PIXEL_NUM and CNT_W defaults, the FSM state encoding, and the widths derived with clog2.
REQ-035 Sub-module peak_cmp holds the registered max/index comparator (strict greater-than, clearable); the FSM and address counter stay in the top module.

Verification
REQ-036 Pixel 0 bins 3 and 9 = 50, others 0, outReady=1 -> outPixel 0, outBin 3, outCount 50, outValid 18 cycles after the first rdEn.
REQ-037 All-zero bank, PIXEL_NUM=4 -> four results with bin 0, count 0, pixels 0..3, then busy falls.
REQ-038 outReady held low 5 cycles in OUT -> outputs stable, no new rdEn, next pixel scan starts the cycle after acceptance.
REQ-039 Two hisNum toggles during one scan -> one pending bank processed afterwards, overrun set.
REQ-040 res pulsed at bin 7 of pixel 1 -> IDLE next cycle, no outValid, busy 0, rdBank 0.
REQ-041 PEAK_THRESH_EN, peakThresh=20, max bin 5 count 20 -> outBin 0, outCount 0; the same bank with count 21 -> outBin 5, outCount 21.
